// File: rtl/data_mux_pkg.sv
// Shared types and helpers for the link data mux / demux pair.
package data_mux_pkg;

  localparam int MAX_OUTPUTS = 16;
  localparam int SEL_W       = $clog2(MAX_OUTPUTS);
  localparam int MAX_DW      = 64;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } rx_state_t;

  // Reverses the low 'width' bits of d; bits above 'width' come back as zero.
  function automatic logic [MAX_DW-1:0] bit_reverse(input logic [MAX_DW-1:0] d,
                                                    input int width);
    logic [MAX_DW-1:0] r;
    r = {<<{d}};
    return r >> (MAX_DW - width);
  endfunction

endpackage

// File: rtl/data_demux_out_reg.sv
// One-deep AXIS holding register with a destination select; decodes the
// per-output valids and produces the upstream ready.
module data_demux_out_reg
  import data_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUTPUTS  = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  bx0_i,
  input  logic [N_OUTPUTS-1:0]  tready_out_i,
  output logic                  ready_o,
  output logic [N_OUTPUTS-1:0]  tvalid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  bx0_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  bx0_q, bx0_d;
  logic [MAX_OUTPUTS-1:0] rdy_ext;
  logic                  drain;

  // Widen so the 4-bit select can always index safely.
  assign rdy_ext = MAX_OUTPUTS'(tready_out_i);
  assign drain   = valid_q && rdy_ext[sel_q];
  assign ready_o = !valid_q || rdy_ext[sel_q];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    bx0_d   = bx0_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sel_d   = sel_i;
      bx0_d   = bx0_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      bx0_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      bx0_q   <= bx0_d;
    end
  end

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_vld
    assign tvalid_o[k] = valid_q && (sel_q == SEL_W'(k));
  end

  assign data_o = data_q;
  assign bx0_o  = bx0_q;

endmodule

// File: rtl/data_demux_rx.sv
// Link RX demux: de-reverses link words, locks on the TX idle pattern,
// checks headers and routes data words to one of N_OUTPUTS AXIS buses.
module data_demux_rx
  import data_mux_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int N_OUTPUTS          = 16,
  parameter int INPUT_REVERSE_BITS = 1
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [DATA_WIDTH-1:0]                tdata_in,
  input  logic                                 tvalid_in,
  output logic                                 tready_in,
  output logic [N_OUTPUTS-1:0][DATA_WIDTH-1:0] tdata_out,
  output logic [N_OUTPUTS-1:0]                 tvalid_out,
  input  logic [N_OUTPUTS-1:0]                 tready_out,
  output logic                                 tuser_bx0_out,
  input  logic [15:0]                          n_lock_idles,
  input  logic [7:0]                           max_header_errors,
  input  logic [3:0]                           output_select,
  input  logic [DATA_WIDTH-1:0]                idle_word,
  input  logic [DATA_WIDTH-1:0]                idle_word_BX0,
  input  logic [DATA_WIDTH-1:0]                header_mask,
  input  logic [DATA_WIDTH-1:0]                header,
  input  logic [DATA_WIDTH-1:0]                header_BX0,
  input  logic                                 fc_linkReset,
  output logic                                 locked,
  output logic [15:0]                          header_err_count,
  output logic                                 bx0_pulse
);

  localparam logic [MAX_OUTPUTS-1:0] SEL_OK = (N_OUTPUTS >= MAX_OUTPUTS) ?
      {MAX_OUTPUTS{1'b1}} : MAX_OUTPUTS'((1 << N_OUTPUTS) - 1);

  logic [DATA_WIDTH-1:0] w;
  logic accept, is_idle, hdr_match, hdrb_match, hdr_ok, is_bx0, sel_ok, fwd;
  logic [15:0] n_eff;
  logic [16:0] idle_inc;
  logic [8:0]  err_inc;
  logic        idle_reach, err_trip;

  rx_state_t   state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  err_run_q, err_run_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        locked_q, bx0_pulse_q;
  logic [DATA_WIDTH-1:0] o_data;

  if (INPUT_REVERSE_BITS != 0) begin : g_rev
    assign w = DATA_WIDTH'(bit_reverse(MAX_DW'(tdata_in), DATA_WIDTH));
  end else begin : g_norev
    assign w = tdata_in;
  end

  assign accept     = tvalid_in && tready_in;
  assign is_idle    = (w == idle_word) || (w == idle_word_BX0);
  assign hdr_match  = (w & header_mask) == (header & header_mask);
  assign hdrb_match = (w & header_mask) == (header_BX0 & header_mask);
  assign hdr_ok     = hdr_match || hdrb_match;
  assign is_bx0     = (w == idle_word_BX0) || hdrb_match;
  assign sel_ok     = SEL_OK[output_select];

  assign n_eff      = (n_lock_idles == 16'd0) ? 16'd1 : n_lock_idles;
  assign idle_inc   = {1'b0, idle_cnt_q} + 17'd1;
  assign idle_reach = idle_inc >= {1'b0, n_eff};
  assign err_inc    = {1'b0, err_run_q} + 9'd1;
  assign err_trip   = (max_header_errors != 8'd0) && (err_inc >= {1'b0, max_header_errors});

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    err_run_d  = err_run_q;
    err_cnt_d  = err_cnt_q;
    fwd        = 1'b0;
    if (fc_linkReset) begin
      state_d    = UNLOCKED;
      idle_cnt_d = '0;
      err_run_d  = '0;
    end else if (accept) begin
      case (state_q)
        // idle_cnt is zero in UNLOCKED, so the same count/compare covers both.
        UNLOCKED, ACQUIRE: begin
          if (is_idle) begin
            if (idle_reach) begin
              state_d    = LOCKED;
              idle_cnt_d = '0;
              err_run_d  = '0;
            end else begin
              state_d    = ACQUIRE;
              idle_cnt_d = idle_inc[15:0];
            end
          end else begin
            state_d    = UNLOCKED;
            idle_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!is_idle) begin
            if (hdr_ok) begin
              err_run_d = '0;
              fwd       = sel_ok;
            end else begin
              err_run_d = err_inc[8] ? 8'hFF : err_inc[7:0];
              err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
              if (err_trip) begin
                state_d   = UNLOCKED;
                err_run_d = '0;
              end
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= UNLOCKED;
      idle_cnt_q  <= '0;
      err_run_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      bx0_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      err_run_q   <= err_run_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= (state_d == LOCKED);
      bx0_pulse_q <= accept && is_bx0;
    end
  end

  data_demux_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_OUTPUTS  (N_OUTPUTS)
  ) u_out (
    .clk          (clk),
    .aresetn      (aresetn),
    .load_i       (fwd),
    .data_i       (w),
    .sel_i        (output_select),
    .bx0_i        (is_bx0),
    .tready_out_i (tready_out),
    .ready_o      (tready_in),
    .tvalid_o     (tvalid_out),
    .data_o       (o_data),
    .bx0_o        (tuser_bx0_out)
  );

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_dout
    assign tdata_out[k] = o_data;
  end

  assign locked           = locked_q;
  assign header_err_count = err_cnt_q;
  assign bx0_pulse        = bx0_pulse_q;

endmodule

// File: tb/tb_data_demux_rx.sv
// Bench for data_demux_rx: directed table, hand sequences for stall/BX0/link
// reset, and randomized traffic against a behavioural model.
module tb_data_demux_rx;

  localparam logic [31:0] IDLE     = 32'hBC50_0000;
  localparam logic [31:0] IDLE_BX0 = 32'h0000_0001;
  localparam logic [31:0] MASK     = 32'hFF00_0000;
  localparam logic [31:0] HDR      = 32'h3C00_0000;
  localparam logic [31:0] HDRB     = 32'h3D00_0000;
  localparam logic [31:0] ERRW     = 32'h5500_0000;

  logic clk = 1'b0;
  logic aresetn;
  logic [31:0] tdata_in;
  logic tvalid_in, tready_in;
  logic [15:0][31:0] tdata_out;
  logic [15:0] tvalid_out, tready_out;
  logic tuser_bx0_out;
  logic [15:0] n_lock_idles;
  logic [7:0] max_header_errors;
  logic [3:0] output_select;
  logic [31:0] idle_word, idle_word_BX0, header_mask, header, header_BX0;
  logic fc_linkReset, locked;
  logic [15:0] header_err_count;
  logic bx0_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_demux_rx #(.DATA_WIDTH(32), .N_OUTPUTS(16), .INPUT_REVERSE_BITS(1)) dut (
    .clk(clk), .aresetn(aresetn), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tready_in(tready_in), .tdata_out(tdata_out), .tvalid_out(tvalid_out),
    .tready_out(tready_out), .tuser_bx0_out(tuser_bx0_out), .n_lock_idles(n_lock_idles),
    .max_header_errors(max_header_errors), .output_select(output_select),
    .idle_word(idle_word), .idle_word_BX0(idle_word_BX0), .header_mask(header_mask),
    .header(header), .header_BX0(header_BX0), .fc_linkReset(fc_linkReset),
    .locked(locked), .header_err_count(header_err_count), .bx0_pulse(bx0_pulse)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  // Behavioural model: lock tracked as a flag plus a run of idles seen.
  bit          m_locked;
  int          m_idles, m_errs, m_errcnt;
  bit          m_has, m_bx0, m_pulse;
  logic [31:0] m_data;
  int          m_sel;

  task automatic mdl_reset();
    m_locked = 0; m_idles = 0; m_errs = 0; m_errcnt = 0;
    m_has = 0; m_bx0 = 0; m_pulse = 0; m_data = '0; m_sel = 0;
  endtask

  task automatic mdl(input bit fc, input bit vld, input logic [31:0] w, input int sel,
                     input logic [15:0] rdy, output bit ready, output bit acc);
    bit idle, ok, bx, fwd;
    int need;
    ready = !m_has || rdy[m_sel];
    acc   = vld && ready;
    idle  = (w == IDLE) || (w == IDLE_BX0);
    ok    = ((w & MASK) == HDR) || ((w & MASK) == HDRB);
    bx    = (w == IDLE_BX0) || ((w & MASK) == HDRB);
    need  = (n_lock_idles == 0) ? 1 : int'(n_lock_idles);
    fwd   = 0;
    if (m_has && rdy[m_sel]) m_has = 0;
    m_pulse = acc && bx;
    if (fc) begin
      m_locked = 0; m_idles = 0; m_errs = 0;
    end else if (acc) begin
      if (!m_locked) begin
        if (idle) begin
          m_idles++;
          if (m_idles >= need) begin m_locked = 1; m_idles = 0; m_errs = 0; end
        end else m_idles = 0;
      end else if (!idle) begin
        if (ok) begin
          m_errs = 0; fwd = (sel < 16);
        end else begin
          m_errs++;
          if (m_errcnt < 65535) m_errcnt++;
          if (max_header_errors != 0 && m_errs >= int'(max_header_errors)) begin
            m_locked = 0; m_errs = 0;
          end
        end
      end
    end
    if (fwd) begin m_has = 1; m_data = w; m_sel = sel; m_bx0 = bx; end
  endtask

  // One cycle: drive at negedge, check ready, check registered outputs after posedge.
  task automatic step(input bit fc, input bit vld, input logic [31:0] w, input int sel,
                      input logic [15:0] rdy, output bit acc);
    bit er;
    fc_linkReset = fc; tvalid_in = vld; tdata_in = rev(w);
    output_select = 4'(sel); tready_out = rdy;
    #1;
    mdl(fc, vld, w, sel, rdy, er, acc);
    chk("tready_in", tready_in, er);
    @(posedge clk); #1;
    chk("locked", locked, m_locked);
    chk("tvalid_out", tvalid_out, m_has ? (16'(1) << m_sel) : 16'h0);
    if (m_has) begin
      chk("tdata_out", tdata_out[m_sel], m_data);
      chk("tuser_bx0_out", tuser_bx0_out, m_bx0);
    end
    chk("header_err_count", header_err_count, m_errcnt);
    chk("bx0_pulse", bx0_pulse, m_pulse);
    @(negedge clk);
  endtask

  task automatic do_reset();
    aresetn = 0; fc_linkReset = 0; tvalid_in = 0; tdata_in = '0;
    output_select = '0; tready_out = '1;
    repeat (2) @(posedge clk);
    #1 chk("rst_tready_in", tready_in, 1'b1);
    @(negedge clk);
    aresetn = 1;
    mdl_reset();
    chk("rst_locked", locked, 1'b0);
    chk("rst_tvalid_out", tvalid_out, 16'h0);
    chk("rst_tdata_out", tdata_out[0], 32'h0);
    chk("rst_bx0_out", tuser_bx0_out, 1'b0);
    chk("rst_err_count", header_err_count, 16'h0);
    chk("rst_bx0_pulse", bx0_pulse, 1'b0);
  endtask

  function automatic logic [31:0] rnd_word();
    int k;
    k = $urandom_range(0, 99);
    if (k < 40) return IDLE;
    if (k < 45) return IDLE_BX0;
    if (k < 75) return {8'h3C, 24'($urandom)};
    if (k < 80) return {8'h3D, 24'($urandom)};
    return {8'h40 + 8'($urandom_range(0, 63)), 24'($urandom)};
  endfunction

  typedef struct {
    logic fc, vld;
    logic [31:0] w;
    logic e_lock;
    logic [15:0] e_ovld;
    logic [31:0] e_data;
    logic [15:0] e_err;
    logic e_pulse;
  } vec_t;

  localparam logic [15:0] OV3 = 16'h0008;

  initial begin
    vec_t tbl[$];
    bit a;
    int idx;
    logic [15:0] saved;
    logic [31:0] dw [8];

    idle_word = IDLE; idle_word_BX0 = IDLE_BX0; header_mask = MASK;
    header = HDR; header_BX0 = HDRB;
    n_lock_idles = 16'd3; max_header_errors = 8'd2;

    // Output 3, all outputs ready: lock, data, link reset, relock, error runs, BX0 idle.
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           1, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, 32'h3C00_1111,  1, OV3,   32'h3C00_1111,  0, 0});
    tbl.push_back('{0, 0, 32'h0,          1, 16'h0, 0,              0, 0});
    tbl.push_back('{1, 0, 32'h0,          0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, ERRW,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           0, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, IDLE,           1, 16'h0, 0,              0, 0});
    tbl.push_back('{0, 1, ERRW,           1, 16'h0, 0,              1, 0});
    tbl.push_back('{0, 1, 32'h3C00_2222,  1, OV3,   32'h3C00_2222,  1, 0});
    tbl.push_back('{0, 1, ERRW,           1, 16'h0, 0,              2, 0});
    tbl.push_back('{0, 1, 32'h3C00_3333,  1, OV3,   32'h3C00_3333,  2, 0});
    tbl.push_back('{0, 1, ERRW,           1, 16'h0, 0,              3, 0});
    tbl.push_back('{0, 1, ERRW,           0, 16'h0, 0,              4, 0});
    tbl.push_back('{0, 1, 32'h3C00_4444,  0, 16'h0, 0,              4, 0});
    tbl.push_back('{0, 1, IDLE_BX0,       0, 16'h0, 0,              4, 1});
    tbl.push_back('{0, 0, 32'h0,          0, 16'h0, 0,              4, 0});

    @(negedge clk);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      fc_linkReset = tbl[i].fc; tvalid_in = tbl[i].vld; tdata_in = rev(tbl[i].w);
      output_select = 4'd3; tready_out = '1;
      #1 chk($sformatf("v%0d_tready_in", i), tready_in, 1'b1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_locked", i), locked, tbl[i].e_lock);
      chk($sformatf("v%0d_tvalid_out", i), tvalid_out, tbl[i].e_ovld);
      if (tbl[i].e_ovld != 0) chk($sformatf("v%0d_tdata_out", i), tdata_out[3], tbl[i].e_data);
      chk($sformatf("v%0d_err_count", i), header_err_count, tbl[i].e_err);
      chk($sformatf("v%0d_bx0_pulse", i), bx0_pulse, tbl[i].e_pulse);
      @(negedge clk);
    end

    // Stall on output 5 for 4 cycles with continuous input; select moves to 2 mid-stall.
    do_reset();
    n_lock_idles = 16'd3; max_header_errors = 8'd0;
    repeat (3) step(0, 1, IDLE, 0, '1, a);
    for (int i = 0; i < 8; i++) dw[i] = 32'h3C00_0A00 + 32'(i);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, idx < 8, (idx < 8) ? dw[idx] : 32'h0, (c < 3) ? 5 : 2,
           (c >= 1 && c <= 4) ? 16'hFFDF : 16'hFFFF, a);
      if (c == 2) begin
        chk("stall_hold_valid", tvalid_out, 16'h0020);
        chk("stall_hold_data", tdata_out[5], 32'h3C00_0A00);
        chk("stall_tready_in", tready_in, 1'b0);
      end
      if (a) idx++;
    end
    chk("stall_accepts", idx, 8);

    // Reversed BX0 idle, lock, then a data word in header_BX0 form.
    do_reset();
    n_lock_idles = 16'd3;
    step(0, 1, IDLE_BX0, 0, '1, a);
    chk("bx0_idle_pulse", bx0_pulse, 1'b1);
    step(0, 1, IDLE, 0, '1, a);
    step(0, 1, IDLE, 0, '1, a);
    step(0, 1, 32'h3D00_0042, 7, '1, a);
    chk("bx0_beat_valid", tvalid_out, 16'h0080);
    chk("bx0_beat_flag", tuser_bx0_out, 1'b1);
    chk("bx0_data_pulse", bx0_pulse, 1'b1);

    // Link reset mid-stream while locked.
    max_header_errors = 8'd0;
    step(0, 1, ERRW, 1, '1, a);
    step(0, 1, 32'h3C00_0100, 1, '1, a);
    saved = header_err_count;
    step(1, 1, 32'h3C00_0101, 1, '1, a);
    chk("fc_locked", locked, 1'b0);
    chk("fc_err_kept", header_err_count, saved);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h3C00_0102 + 32'(i), 1, '1, a);
    chk("fc_no_output", tvalid_out, 16'h0);

    // Random traffic against the model, a few lock/error settings.
    for (int seg = 0; seg < 4; seg++) begin
      n_lock_idles      = 16'(seg);
      max_header_errors = 8'((seg + 1) % 4);
      for (int c = 0; c < 150; c++)
        step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, rnd_word(),
             $urandom_range(0, 15),
             ($urandom_range(0, 2) != 0) ? 16'hFFFF : 16'($urandom), a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_demux_rx.md
Name: data_demux_rx

Overview:
Receive-side counterpart of the TX data mux.
- Accepts one AXIS word stream from the link and undoes the TX bit reversal.
- Acquires word lock on the idle pattern that TX sends after fc_linkReset, then drops idle words.
- Checks header bits on data words, flags BX0 words, and routes valid data words to one of N_OUTPUTS AXIS outputs.
- Sits between the link deserializer and the per-channel consumers.

Parameters:
- DATA_WIDTH, 32, word width.
- N_OUTPUTS, 16, number of output AXIS buses (max 16, indexed by output_select).
- INPUT_REVERSE_BITS, 1, when 1, tdata_in bit i maps to internal bit DATA_WIDTH-1-i before any compare.

Ports:
- clk  in  1  clock.
- aresetn  in  1  reset: synchronous, active-low, sampled on the rising edge of clk.
- tdata_in  in  DATA_WIDTH  link word.
- tvalid_in  in  1  link word valid.
- tready_in  out  1  link ready.
- tdata_out  out  DATA_WIDTH x N_OUTPUTS  per-output data (de-reversed word, header bits kept).
- tvalid_out  out  1 x N_OUTPUTS  per-output valid.
- tready_out  in  1 x N_OUTPUTS  per-output ready.
- tuser_bx0_out  out  1  held-beat BX0 flag; shared by all outputs.
- n_lock_idles  in  16  consecutive idle words required for lock; 0 is treated as 1.
- max_header_errors  in  8  consecutive header errors that drop lock; 0 means never drop.
- output_select  in  4  destination output index.
- idle_word  in  DATA_WIDTH  idle pattern.
- idle_word_BX0  in  DATA_WIDTH  idle pattern at BX0.
- header_mask  in  DATA_WIDTH  header bit mask.
- header  in  DATA_WIDTH  expected header.
- header_BX0  in  DATA_WIDTH  expected header at BX0.
- fc_linkReset  in  1  forces unlock.
- locked  out  1  lock status.
- header_err_count  out  16  saturating total header errors.
- bx0_pulse  out  1  one-cycle pulse per accepted BX0 word (idle or data).

Behaviour:
- Internal word w = tdata_in, bit-reversed when INPUT_REVERSE_BITS=1. A word is accepted on tvalid_in && tready_in.
- Classification of an accepted word:
  - IDLE if w == idle_word or w == idle_word_BX0.
  - HDR_OK if (w & header_mask) == (header & header_mask) or == (header_BX0 & header_mask).
  - Otherwise HDR_ERR.
  - BX0 if w matches idle_word_BX0, or the header_BX0 header form.
- State machine, states UNLOCKED, ACQUIRE, LOCKED:
  - UNLOCKED: IDLE word -> ACQUIRE with idle_cnt=1. If n_lock_idles<=1 -> LOCKED directly.
  - ACQUIRE: IDLE word -> idle_cnt+1; idle_cnt reaching n_lock_idles -> LOCKED. Any non-IDLE word -> UNLOCKED, idle_cnt=0.
  - LOCKED: IDLE words dropped, no error. HDR_OK word forwarded, err_run=0. HDR_ERR word dropped, err_run+1, header_err_count+1 (saturates at 16'hFFFF). err_run reaching max_header_errors (nonzero) -> UNLOCKED.
  - fc_linkReset=1 in any state -> UNLOCKED next cycle, idle_cnt=0, err_run=0; the word accepted that cycle is dropped. fc_linkReset has priority over all other transitions. header_err_count is not cleared by fc_linkReset.
- Words accepted while not LOCKED are never forwarded. locked=1 iff state==LOCKED (registered).
- Output stage is one register: o_valid, o_data, o_sel, o_bx0.
  - tready_in = !o_valid || tready_out[o_sel] (combinational).
  - A forwarded word loads the register with o_sel=output_select sampled at acceptance. output_select changes never re-route a held beat.
  - tvalid_out[k] = o_valid && (o_sel==k). tdata_out[k] = o_data for all k. tuser_bx0_out = o_bx0.
  - output_select >= N_OUTPUTS: the word is dropped (counted as accepted, not forwarded).
- Latency: accepted word to tvalid_out is 1 cycle. Full throughput of 1 word/cycle when the selected output is ready.
- bx0_pulse is registered: asserted the cycle after any accepted BX0 word in any state.
- Reset: state=UNLOCKED, o_valid=0, o_data=0, o_sel=0, o_bx0=0, locked=0, header_err_count=0, bx0_pulse=0, counters=0. tready_in=1 during and after reset.
- Simultaneous load and drain: register reloads in the same cycle; no bubble.

Decomposition:
- Package data_mux_pkg:
  - rx_state_t enum {UNLOCKED, ACQUIRE, LOCKED}.
  - function bit_reverse(DATA_WIDTH).
  - MAX_OUTPUTS=16.
- Sub-module data_demux_out_reg: a one-deep AXIS register with a select field, driving the N_OUTPUTS valid decode.

Test Plan:
- Reset, then 3 idle_word with n_lock_idles=3 -> locked rises the cycle after the 3rd accept. Following word (w & header_mask)==header appears on tvalid_out[output_select] 1 cycle after accept.
- Idle, idle, HDR_ERR word, idle with n_lock_idles=3 -> state returns to UNLOCKED after the error word; locked stays 0; lock reached only after 3 further idles.
- Locked, max_header_errors=2: HDR_ERR, HDR_OK, HDR_ERR -> stays locked, header_err_count=2. A further 2 consecutive HDR_ERR -> locked falls and header_err_count=4.
- Locked, output_select=5, tready_out[5]=0 for 4 cycles with continuous input -> tready_in=0 after 1 beat, held data stable, no words lost, in-order delivery once ready. Changing output_select to 2 mid-stall still delivers the held beat on output 5.
- INPUT_REVERSE_BITS=1, idle_word_BX0=32'h0000_0001 sent reversed (32'h8000_0000) -> classified idle, bx0_pulse=1 next cycle. Data word matching the header_BX0 form -> tuser_bx0_out=1 with its beat.
- fc_linkReset asserted while locked mid-stream -> locked=0 next cycle, no further tvalid_out until relock. header_err_count unchanged.
